// File: rtl/msu_pkg.sv
// Shared types and constants for the MSU audio path.
package msu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_L,
    ST_LAT_L,
    ST_RD_R,
    ST_LAT_R,
    ST_SCALE,
    ST_PRESENT
  } player_state_t;

  localparam int         SAMPLE_HZ_DEFAULT  = 44100;
  localparam logic [8:0] VOL_UNITY          = 9'd256;
  localparam int         UNDERRUN_MIN_WORDS = 2;

  // 255 maps to 256 so that full volume is an exact pass-through.
  function automatic logic [15:0] apply_volume(input logic signed [15:0] raw,
                                               input logic [7:0] vol);
    logic [8:0]         eff;
    logic signed [24:0] a;
    logic signed [24:0] b;
    logic signed [24:0] prod;
    eff  = (vol == 8'hFF) ? VOL_UNITY : {1'b0, vol};
    a    = 25'(raw);
    b    = 25'($signed({1'b0, eff}));
    prod = a * b;
    return 16'(prod >>> 8);
  endfunction

endpackage

// File: rtl/msu_rate_gen.sv
// Fractional accumulator: one-cycle tick at exactly SAMPLE_HZ on average from CLK_HZ.
module msu_rate_gen #(
  parameter int CLK_HZ    = 21477272,
  parameter int SAMPLE_HZ = 44100,
  parameter int ACC_W     = 32
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [ACC_W-1:0] STEP = ACC_W'(SAMPLE_HZ);
  localparam logic [ACC_W-1:0] WRAP = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_next;
  logic             r_tick;

  assign w_next = r_acc + STEP;
  assign tick   = r_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_tick <= 1'b0;
    end else if (w_next >= WRAP) begin
      r_acc  <= w_next - WRAP;
      r_tick <= 1'b1;
    end else begin
      r_acc  <= w_next;
      r_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/msu_audio_player.sv
// Drains the MSU sample FIFO one stereo pair per tick, applies volume, and
// presents registered samples; silence on pause or underrun.
module msu_audio_player
  import msu_pkg::*;
#(
  parameter int CLK_HZ    = 21477272,
  parameter int SAMPLE_HZ = SAMPLE_HZ_DEFAULT,
  parameter int ACC_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        audio_play,
  input  logic [15:0] fifo_q,
  input  logic [11:0] fifo_usedw,
  input  logic [7:0]  volume,
  output logic        fifo_rdreq,
  output logic [15:0] left_out,
  output logic [15:0] right_out,
  output logic        sample_strobe,
  output logic        underrun,
  output logic [15:0] underrun_count
);

  logic          w_tick;
  player_state_t r_state;
  logic [15:0]   r_raw_l, r_raw_r;
  logic [15:0]   r_scaled_l, r_scaled_r;
  logic          r_rdreq, r_strobe, r_underrun;
  logic [15:0]   r_left, r_right, r_ucount;

  msu_rate_gen #(
    .CLK_HZ   (CLK_HZ),
    .SAMPLE_HZ(SAMPLE_HZ),
    .ACC_W    (ACC_W)
  ) u_rate_gen (
    .clk  (clk),
    .reset(reset),
    .tick (w_tick)
  );

  assign fifo_rdreq     = r_rdreq;
  assign left_out       = r_left;
  assign right_out      = r_right;
  assign sample_strobe  = r_strobe;
  assign underrun       = r_underrun;
  assign underrun_count = r_ucount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_raw_l    <= '0;
      r_raw_r    <= '0;
      r_scaled_l <= '0;
      r_scaled_r <= '0;
      r_rdreq    <= 1'b0;
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;
      r_left     <= '0;
      r_right    <= '0;
      r_ucount   <= '0;
    end else begin
      r_rdreq    <= 1'b0;
      r_strobe   <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            if (audio_play && (fifo_usedw >= 12'(UNDERRUN_MIN_WORDS))) begin
              r_rdreq <= 1'b1;
              r_state <= ST_RD_L;
            end else begin
              r_raw_l <= '0;
              r_raw_r <= '0;
              r_state <= ST_SCALE;
              if (audio_play) begin
                r_underrun <= 1'b1;
                if (r_ucount != 16'hFFFF) r_ucount <= r_ucount + 16'd1;
              end
            end
          end
        end
        ST_RD_L:  r_state <= ST_LAT_L;
        ST_LAT_L: begin
          r_raw_l <= fifo_q;
          r_rdreq <= 1'b1;
          r_state <= ST_RD_R;
        end
        ST_RD_R:  r_state <= ST_LAT_R;
        ST_LAT_R: begin
          r_raw_r <= fifo_q;
          r_state <= ST_SCALE;
        end
        ST_SCALE: begin
          r_scaled_l <= apply_volume(r_raw_l, volume);
          r_scaled_r <= apply_volume(r_raw_r, volume);
          r_state    <= ST_PRESENT;
        end
        ST_PRESENT: begin
          r_left   <= r_scaled_l;
          r_right  <= r_scaled_r;
          r_strobe <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
